e_dec_digits: RTL and testbench



---
 rtl/e_calc_pkg.sv | 19 +
 rtl/e_mul10_word.sv | 22 ++
 rtl/e_dec_digits.sv | 137 +++++++++++++
 tb/tb_e_dec_digits.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/e_calc_pkg.sv
// Shared definitions for the e calculator and its decimal digit emitter.
//   WORD_W        : width of one operand word.
//   e_dec_state_t : digit emitter controller states.
//   bcd_t         : one BCD digit.
package e_calc_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT_INT,
    S_MUL,
    S_EMIT_FRAC,
    S_DONE
  } e_dec_state_t;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/e_mul10_word.sv
// One word step of a word-serial multiply-by-10.
//   word      in  : current fraction word
//   carry_in  in  : carry from the next-less-significant word
//   word_out  out : low 16 bits of word*10 + carry_in
//   carry_out out : bits above the word (never above 9 when carry_in <= 9)
module e_mul10_word
  import e_calc_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  bcd_t              carry_in,
  output logic [WORD_W-1:0] word_out,
  output bcd_t              carry_out
);

  logic [WORD_W+3:0] w_p;

  // word*10 as word*8 + word*2
  assign w_p       = ({4'b0, word} << 3) + ({4'b0, word} << 1) + {{WORD_W{1'b0}}, carry_in};
  assign word_out  = w_p[WORD_W-1:0];
  assign carry_out = w_p[WORD_W+3:WORD_W];

endmodule

// File: rtl/e_dec_digits.sv
// Converts a multiword fixed-point value (integer part in the top word) into
// a stream of BCD digits: integer digit first, then NUM_DIGITS fractional
// digits obtained by repeated multiply-by-10 of the fraction.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : capture in_data and begin (only in IDLE or DONE)
//   in_data      : WORDS x 16-bit words, word 0 least significant
//   busy         : conversion in progress
//   digit_valid  : digit is presented
//   digit_ready  : consumer accepts digit
//   digit        : BCD digit
//   digit_last   : final fractional digit
//   done         : conversion finished (or aborted on range error)
//   err_range    : integer word >= 10, held until the next accepted start
module e_dec_digits
  import e_calc_pkg::*;
#(
  parameter int WORDS      = 32,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WORDS*WORD_W-1:0] in_data,
  output logic                    busy,
  output logic                    digit_valid,
  input  logic                    digit_ready,
  output logic [3:0]              digit,
  output logic                    digit_last,
  output logic                    done,
  output logic                    err_range
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);

  e_dec_state_t      r_state;
  e_dec_state_t      w_next;
  logic [WORD_W-1:0] r_work [0:WORDS-2];
  logic [WORD_W-1:0] r_int;
  bcd_t              r_carry;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;

  logic              w_int_ok;
  logic              w_last;
  logic [WORD_W-1:0] w_mul_out;
  bcd_t              w_mul_carry;

  e_mul10_word u_mul10 (
    .word      (r_work[r_idx]),
    .carry_in  (r_carry),
    .word_out  (w_mul_out),
    .carry_out (w_mul_carry)
  );

  assign w_int_ok = (r_int < WORD_W'(10));
  assign w_last   = (r_state == S_EMIT_FRAC) && (r_count == CNT_LAST);

  // Outputs decode only state and registers; digit_ready never reaches them.
  assign busy        = !((r_state == S_IDLE) || (r_state == S_DONE));
  assign done        = (r_state == S_DONE);
  assign digit_valid = ((r_state == S_EMIT_INT) && w_int_ok) || (r_state == S_EMIT_FRAC);
  assign digit       = (r_state == S_EMIT_INT)  ? r_int[3:0] :
                       (r_state == S_EMIT_FRAC) ? r_carry    : 4'd0;
  assign digit_last  = w_last;
  assign err_range   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_EMIT_INT;
      S_EMIT_INT: begin
        if (!w_int_ok)        w_next = S_DONE;
        else if (digit_ready) w_next = S_MUL;
      end
      S_MUL:       if (r_idx == IDX_LAST) w_next = S_EMIT_FRAC;
      S_EMIT_FRAC: if (digit_ready) w_next = w_last ? S_DONE : S_MUL;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS - 1; i++) r_work[i] <= '0;
      r_int   <= '0;
      r_carry <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int i = 0; i < WORDS - 1; i++) r_work[i] <= in_data[i*WORD_W +: WORD_W];
            r_int   <= in_data[(WORDS-1)*WORD_W +: WORD_W];
            r_count <= '0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_carry <= '0;
          end
        end
        S_EMIT_INT: begin
          if (!w_int_ok) begin
            r_err <= 1'b1;
          end else if (digit_ready) begin
            r_idx   <= '0;
            r_carry <= '0;
          end
        end
        S_MUL: begin
          r_work[r_idx] <= w_mul_out;
          r_carry       <= w_mul_carry;
          if (r_idx != IDX_LAST) r_idx <= r_idx + 1'b1;
        end
        S_EMIT_FRAC: begin
          // The digit is the carry out of the top fraction word; each pass
          // starts again from word 0 with no carry.
          if (digit_ready) begin
            r_count <= r_count + 1'b1;
            r_idx   <= '0;
            r_carry <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_e_dec_digits.sv
module tb_e_dec_digits;
  localparam int WORDS      = 32;
  localparam int NUM_DIGITS = 8;
  localparam int DW         = WORDS * 16;
  localparam int FW         = (WORDS - 1) * 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          busy, digit_valid, digit_last, done, err_range;
  logic          digit_ready = 1'b0;
  logic [3:0]    digit;

  e_dec_digits #(.WORDS(WORDS), .NUM_DIGITS(NUM_DIGITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_data     (in_data),
    .busy        (busy),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .digit       (digit),
    .digit_last  (digit_last),
    .done        (done),
    .err_range   (err_range)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   hs_count = 0;
  int   ready_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: treat the fraction as one big binary number and multiply it
  // by ten; the bits spilling above the binary point are the next digit.
  function automatic void push_expected(input logic [DW-1:0] v);
    logic [FW-1:0] f;
    logic [FW+3:0] p;
    logic [15:0]   ip;
    exp_t          e;
    ip = v[DW-1 -: 16];
    f  = v[FW-1:0];
    if (ip >= 16'd10) return;
    e.d = ip[3:0];
    e.l = 1'b0;
    q.push_back(e);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      p   = ({4'b0, f} << 3) + ({4'b0, f} << 1);
      e.d = p[FW+3:FW];
      e.l = (k == NUM_DIGITS - 1);
      q.push_back(e);
      f   = p[FW-1:0];
    end
  endfunction

  function automatic logic [DW-1:0] mk(input logic [15:0] w31, w30, w29, w28, w27);
    logic [DW-1:0] v;
    v = '0;
    v[DW-1  -: 16] = w31;
    v[DW-17 -: 16] = w30;
    v[DW-33 -: 16] = w29;
    v[DW-49 -: 16] = w28;
    v[DW-65 -: 16] = w27;
    return v;
  endfunction

  // Consumer: 0 = always ready, 1 = random, 2 = stall 5 cycles per digit
  initial begin
    int stall;
    stall = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: digit_ready = 1'b1;
        1: digit_ready = 1'($urandom_range(0, 1));
        default: begin
          if (digit_valid) begin
            if (stall < 5) begin
              digit_ready = 1'b0;
              stall++;
            end else begin
              digit_ready = 1'b1;
              stall = 0;
            end
          end else begin
            digit_ready = 1'b0;
            stall = 0;
          end
        end
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic       hold_v;
    logic [3:0] hold_d;
    logic       hold_l;
    exp_t       e;
    hold_v = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) chk("stall_stable", {digit_valid, digit, digit_last}, {1'b1, hold_d, hold_l});
        if (digit_valid && q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got digit %0d expected no digit at %0t", digit, $time);
        end
        if (digit_valid && digit_ready) begin
          hold_v = 1'b0;
          hs_count++;
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("digit", digit, e.d);
            chk("digit_last", digit_last, e.l);
          end
        end else if (digit_valid) begin
          hold_v = 1'b1;
          hold_d = digit;
          hold_l = digit_last;
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  task automatic randomize_input();
    for (int i = 0; i < WORDS; i++) in_data[i*16 +: 16] = 16'($urandom);
  endtask

  task automatic accept(input logic [DW-1:0] v, input bit exp_err);
    push_expected(v);
    in_data = v;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    randomize_input();
    chk("busy_after_start", busy, 1);
    chk("err_clear_on_start", err_range, 0);
    chk("int_valid_next_cycle", digit_valid, !exp_err);
  endtask

  task automatic run_case(input logic [DW-1:0] v, input int mode, input bit pulse_starts);
    int n;
    bit exp_err;
    ready_mode = mode;
    @(posedge clk);
    #1;
    n = 0;
    while (busy && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    exp_err = (v[DW-1 -: 16] >= 16'd10);
    accept(v, exp_err);
    n = 1;
    while (!done && n < 30000) begin
      if (pulse_starts && busy && (n % 37 == 0)) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    chk("done_reached", done, 1);
    chk("busy_in_done", busy, 0);
    chk("err_range", err_range, exp_err);
    chk("queue_drained", q.size(), 0);
    q.delete();
    if (mode == 0 && !pulse_starts)
      chk("cycles_to_done", n, exp_err ? 2 : 1 + (NUM_DIGITS + 1) + NUM_DIGITS * (WORDS - 1));
    if (exp_err) begin
      repeat (3) @(posedge clk);
      #1;
      chk("err_held", {err_range, done, digit_valid}, 3'b110);
    end
  endtask

  task automatic reset_mid_stream(input logic [DW-1:0] v);
    int n;
    int base;
    ready_mode = 0;
    @(posedge clk);
    #1;
    base = hs_count;
    accept(v, 1'b0);
    n = 0;
    while (hs_count < base + 3 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("third_digit_seen", hs_count - base, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_outputs_zero", {busy, digit_valid, digit_last, done, err_range, digit}, 9'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] e_val, half, ones, v;
    e_val = mk(16'd2, 16'hB7E1, 16'h5162, 16'h8AED, 16'h2A6A);
    half  = mk(16'd0, 16'h8000, 16'h0, 16'h0, 16'h0);
    ones  = '1;
    ones[DW-1 -: 16] = 16'd0;

    #12;
    chk("reset_outputs", {busy, digit_valid, digit_last, done, err_range, digit}, 9'd0);
    #1;
    rst_n = 1'b1;

    run_case(e_val, 0, 1'b0);
    run_case(half,  0, 1'b0);
    run_case(ones,  0, 1'b0);
    run_case(mk(16'd10, 16'h1234, 16'h0, 16'h0, 16'h0), 0, 1'b0);
    run_case(e_val, 2, 1'b1);
    reset_mid_stream(e_val);
    run_case(e_val, 0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      v = '0;
      for (int i = 0; i < WORDS - 1; i++) v[i*16 +: 16] = 16'($urandom);
      v[DW-1 -: 16] = 16'($urandom_range(0, 11));
      run_case(v, 1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
